// File: rtl/lazarus_pkg.sv
// Shared definitions for the game-speed controller: state encodings,
// divider select codes and the level-to-select mapping.
package lazarus_pkg;

    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned SCORE_W   = 14;
    localparam int unsigned LIVES_W   = 2;
    localparam int unsigned HIT_CNT_W = 8;
    localparam int unsigned SEL_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } gameState_e;

    localparam logic [SEL_W-1:0] SEL_SLOW = 4'd0;
    localparam logic [SEL_W-1:0] SEL_TEST = 4'd1;
    localparam logic [SEL_W-1:0] SEL_BASE = 4'd2;

    localparam int unsigned SCORE_MAX_DEF = 9999;

    // Level 0 uses the slowest rate; level k maps to code k+1, skipping the test rate.
    function automatic logic [SEL_W-1:0] levelToSel(input logic [LEVEL_W-1:0] lvl);
        if (lvl == '0) begin
            return SEL_SLOW;
        end
        return SEL_BASE + SEL_W'(lvl - LEVEL_W'(1));
    endfunction

endpackage

// File: rtl/level_ctrl_rise_detect.sv
// Registers a level input and flags the cycle in which it goes from low to high.
module rise_detect
    import lazarus_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic D,
    output logic Rise_c
);

    logic dQ;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dQ <= 1'b0;
        end else begin
            dQ <= D;
        end
    end

    assign Rise_c = D & ~dQ;

endmodule

// File: rtl/level_ctrl.sv
// Game-speed controller: game state machine, hit/level/lives/score tracking,
// and step-enable generation from the divider's slow square wave.
module level_ctrl
    import lazarus_pkg::*;
#(
    parameter int unsigned HITS_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int unsigned START_LEVEL    = 0,
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned SCORE_MAX      = SCORE_MAX_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Pause,
    input  logic               Hit,
    input  logic               Miss,
    input  logic               Tick,
    output logic [SEL_W-1:0]   LevelSel,
    output logic [LEVEL_W-1:0] Level,
    output logic [SCORE_W-1:0] Score,
    output logic [LIVES_W-1:0] Lives,
    output logic [1:0]         State,
    output logic               StepEn,
    output logic               LevelUp,
    output logic               GameOver
);

    gameState_e             curState;
    logic [HIT_CNT_W-1:0]   hitCnt;
    logic                   tickRise;

    rise_detect u_tickEdge (
        .Clk    (Clk),
        .Rst    (Rst),
        .D      (Tick),
        .Rise_c (tickRise)
    );

    assign State = curState;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            curState <= ST_IDLE;
            Level    <= LEVEL_W'(START_LEVEL);
            Score    <= '0;
            Lives    <= LIVES_W'(LIVES_INIT);
            hitCnt   <= '0;
            LevelSel <= levelToSel(LEVEL_W'(START_LEVEL));
            StepEn   <= 1'b0;
            LevelUp  <= 1'b0;
            GameOver <= 1'b0;
        end else begin
            StepEn   <= (curState == ST_RUN) && tickRise;
            LevelUp  <= 1'b0;
            // Rewriting the same code each cycle keeps the divider from re-syncing.
            LevelSel <= levelToSel(Level);

            case (curState)
                ST_IDLE, ST_OVER: begin
                    if (Start) begin
                        curState <= ST_RUN;
                        Level    <= LEVEL_W'(START_LEVEL);
                        Score    <= '0;
                        Lives    <= LIVES_W'(LIVES_INIT);
                        hitCnt   <= '0;
                        GameOver <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (Hit) begin
                        if (Score < SCORE_W'(SCORE_MAX)) begin
                            Score <= Score + SCORE_W'(1);
                        end
                        if (hitCnt == HIT_CNT_W'(HITS_PER_LEVEL - 1)) begin
                            hitCnt <= '0;
                            if (Level < LEVEL_W'(MAX_LEVEL)) begin
                                Level   <= Level + LEVEL_W'(1);
                                LevelUp <= 1'b1;
                            end
                        end else begin
                            hitCnt <= hitCnt + HIT_CNT_W'(1);
                        end
                    end

                    if (Miss && (Lives != '0)) begin
                        Lives <= Lives - LIVES_W'(1);
                    end

                    // Losing the last life outranks a simultaneous pause request.
                    if (Miss && (Lives == LIVES_W'(1))) begin
                        curState <= ST_OVER;
                        GameOver <= 1'b1;
                    end else if (Pause) begin
                        curState <= ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (Pause) begin
                        curState <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule
